seq_multiplier_32bit: RTL and testbench



---
 rtl/seq_multiplier_32bit_if.sv | 22 ++
 rtl/seq_multiplier_32bit.sv | 89 ++++++++
 tb/tb_seq_multiplier_32bit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_32bit_if.sv
// Request/result bundle for the iterative shift-add multiplier.
// The master drives operands and start; the slave returns product, busy and done.
interface seq_multiplier_32bit_if #(
  parameter int WIDTH = 32
);
  logic                   start;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic [2*WIDTH-1:0]     product;
  logic                   busy;
  logic                   done;

  modport master (
    output start, multiplicand, multiplier,
    input  product, busy, done
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output product, busy, done
  );
endinterface

// File: rtl/seq_multiplier_32bit.sv
// Unsigned shift-add multiplier that retires one multiplier bit per clock.
// The done pulse is the load enable of the downstream 2*WIDTH-bit result register.
module seq_multiplier_32bit #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_multiplier_32bit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]           state;
  logic [WIDTH-1:0]     mcand_q;
  logic [2*WIDTH-1:0]   p_q;
  logic [2*WIDTH-1:0]   p_next;
  logic [2*WIDTH-1:0]   product_q;
  logic [CW-1:0]        cnt_q;
  logic                 busy_q;
  logic                 done_q;

  // One iteration: conditionally add the multiplicand into the upper half, then
  // shift right. The add keeps its carry so full-scale operands stay exact.
  function automatic logic [2*WIDTH-1:0] shift_add_step(
    input logic [2*WIDTH-1:0] p,
    input logic [WIDTH-1:0]   mcand
  );
    logic [WIDTH:0] sum;
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    return {sum, p[WIDTH-1:1]};
  endfunction

  always_comb begin
    p_next = shift_add_step(p_q, mcand_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mcand_q   <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand_q <= bus.multiplicand;
            p_q     <= {{WIDTH{1'b0}}, bus.multiplier};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          p_q   <= p_next;
          cnt_q <= cnt_q + 1'b1;
          // Final step publishes the stepped value directly, saving a cycle.
          if (cnt_q == LAST) begin
            product_q <= p_next;
            done_q    <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.product = product_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_seq_multiplier_32bit.sv
// Bench for seq_multiplier_32bit: directed table, random operands against a
// plain-arithmetic product model, and hand sequences for start/reset corner cases.
module tb_seq_multiplier_32bit;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  seq_multiplier_32bit_if #(.WIDTH(32)) bus ();

  seq_multiplier_32bit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Runs one multiply. poke: RUN cycle index at which a competing start is
  // raised for one cycle (0 = never). poke_done: raise start during DONE.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                       input int poke, input bit poke_done);
    int          edges;
    int          busy_cnt;
    logic [63:0] prev;
    bit          held;
    @(negedge clk);
    prev = bus.product;
    held = 1'b1;
    bus.start = 1'b1;
    bus.multiplicand = a;
    bus.multiplier = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.multiplicand = $urandom;
    bus.multiplier = $urandom;
    edges = 1;
    busy_cnt = 0;
    while (!bus.done && edges < 100) begin
      if (bus.busy) busy_cnt++;
      if (bus.product !== prev) held = 1'b0;
      bus.start = (edges == poke);
      if (edges == poke) begin
        bus.multiplicand = 32'h0000_0003;
        bus.multiplier = 32'h0000_0005;
      end
      @(posedge clk); #1;
      edges++;
    end
    bus.start = poke_done;
    chk("done_latency", 64'(edges), 64'd33);
    chk("product", bus.product, exp);
    chk("product_held_during_run", 64'(held), 64'd1);
    if (bus.busy) busy_cnt++;
    chk("busy_cycles", 64'(busy_cnt), 64'd33);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("done_one_cycle", 64'(bus.done), 64'd0);
    chk("busy_fall", 64'(bus.busy), 64'd0);
    chk("product_after_done", bus.product, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[7];
    int          dn;
    int          cyc;
    int          nd;
    int          t[2];
    logic [63:0] p[2];
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] hold_val;

    tbl[0] = '{32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F};
    tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    tbl[2] = '{32'h1234_5678, 32'h0000_0000, 64'h0000_0000_0000_0000};
    tbl[3] = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};
    tbl[4] = '{32'h0000_0000, 32'hFFFF_FFFF, 64'h0000_0000_0000_0000};
    tbl[5] = '{32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF};
    tbl[6] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};

    // Reset with start asserted: reset must win.
    rst = 1'b1;
    bus.start = 1'b1;
    bus.multiplicand = 32'h0000_0007;
    bus.multiplier = 32'h0000_0009;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_product", bus.product, 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;

    for (int i = 0; i < 7; i++)
      do_op(tbl[i].a, tbl[i].b, tbl[i].exp, 0, 1'b0);

    for (int i = 0; i < 15; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = 32'hFFFF_FFFF;
      do_op(ra, rb, model_mul(ra, rb), 0, 1'b0);
    end

    // Competing start mid-RUN and during DONE must both be ignored.
    ra = 32'hDEAD_BEEF;
    rb = 32'h0000_1234;
    do_op(ra, rb, model_mul(ra, rb), 10, 1'b1);
    hold_val = model_mul(ra, rb);
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) dn++;
    end
    chk("ignored_start_extra_done", 64'(dn), 64'd0);
    chk("ignored_start_product_hold", bus.product, hold_val);

    // Abort 7 x 9 after 16 steps.
    @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand = 32'd7;
    bus.multiplier = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_product", bus.product, 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) dn++;
    end
    chk("abort_no_done", 64'(dn), 64'd0);

    // Back-to-back with start held high: results W+2 cycles apart.
    @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand = 32'd7;
    bus.multiplier = 32'd9;
    cyc = 0;
    nd = 0;
    t[0] = 0;
    t[1] = 0;
    p[0] = '0;
    p[1] = '0;
    while (nd < 2 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done) begin
        t[nd] = cyc;
        p[nd] = bus.product;
        nd++;
      end
    end
    bus.start = 1'b0;
    chk("b2b_done_count", 64'(nd), 64'd2);
    chk("b2b_first_latency", 64'(t[0]), 64'd33);
    chk("b2b_first_product", p[0], 64'd63);
    chk("b2b_second_product", p[1], 64'd63);
    chk("b2b_done_spacing", 64'(t[1] - t[0]), 64'd34);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
